// File: rtl/cell_pkg.sv
// Shared constants for the cell elements: default word MSB and running-sum width.
package cell_pkg;

    localparam int unsigned CELL_MSB = 31;

    // One extra bit beyond sample + depth growth keeps the signed sum overflow-free.
    function automatic int unsigned sum_width(input int unsigned msb, input int unsigned depth_log2);
        return msb + 1 + depth_log2 + 1;
    endfunction

endpackage

// File: rtl/sample_ring.sv
// Sample history ring: one synchronous write port, one combinational read port, no reset.
module sample_ring
    import cell_pkg::*;
#(
    parameter int unsigned MSB        = CELL_MSB,
    parameter int unsigned DEPTH_LOG2 = 4
) (
    input  logic                  clk,
    input  logic                  we_i,
    input  logic [DEPTH_LOG2-1:0] waddr_i,
    input  logic [MSB:0]          wdata_i,
    input  logic [DEPTH_LOG2-1:0] raddr_i,
    output logic [MSB:0]          rdata_o
);

    logic [MSB:0] mem_q [2**DEPTH_LOG2];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/moving_average.sv
// Windowed running mean over the last 2^k samples, 1-cycle latency.
// Define MOVING_AVERAGE_FILL_GATE_EN to suppress outputs until the window is full.
module moving_average
    import cell_pkg::*;
#(
    parameter int unsigned MSB              = CELL_MSB,
    parameter int unsigned DEPTH_LOG2       = 4,
    parameter int unsigned DEFAULT_WIN_LOG2 = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [MSB:0] data_in,
    input  logic         data_en,
    input  logic [MSB:0] param_in,
    input  logic         param_en,
    output logic [MSB:0] data_out,
    output logic         data_en_out,
    output logic         full
);

    localparam int unsigned SUMW = sum_width(MSB, DEPTH_LOG2);
    localparam int unsigned KW   = DEPTH_LOG2 + 1;

    logic [KW-1:0]          k_q, k_d, k_new, win;
    logic [KW-1:0]          fill_q, fill_d;
    logic [DEPTH_LOG2-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr;
    logic signed [SUMW-1:0] sum_q, sum_d, din_ext, old_ext, shifted;
    logic [MSB:0]           data_out_q, data_out_d, old_sample;
    logic                   en_out_q, en_out_d, accept, window_full;
    logic                   unused_bits;

    sample_ring #(
        .MSB        (MSB),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_ring (
        .clk     (clk),
        .we_i    (accept),
        .waddr_i (wr_ptr_q),
        .wdata_i (data_in),
        .raddr_i (rd_ptr),
        .rdata_o (old_sample)
    );

    always_comb begin
        k_new       = (param_in[KW-1:0] > KW'(DEPTH_LOG2)) ? KW'(DEPTH_LOG2) : param_in[KW-1:0];
        win         = KW'(1) << k_q;
        // For k = DEPTH_LOG2 the window bit falls outside the pointer, so rd_ptr == wr_ptr_q.
        rd_ptr      = wr_ptr_q - win[DEPTH_LOG2-1:0];
        window_full = (fill_q >= win);
        accept      = data_en && !param_en;
        din_ext     = {{(SUMW-MSB-1){data_in[MSB]}}, data_in};
        old_ext     = {{(SUMW-MSB-1){old_sample[MSB]}}, old_sample};

        k_d        = k_q;
        fill_d     = fill_q;
        wr_ptr_d   = wr_ptr_q;
        sum_d      = sum_q;
        data_out_d = data_out_q;
        en_out_d   = 1'b0;
        shifted    = sum_q >>> k_q;

        if (param_en) begin
            k_d      = k_new;
            fill_d   = '0;
            wr_ptr_d = '0;
            sum_d    = '0;
        end else if (data_en) begin
            wr_ptr_d = wr_ptr_q + DEPTH_LOG2'(1);
            if (window_full) begin
                sum_d = sum_q + din_ext - old_ext;
            end else begin
                sum_d = sum_q + din_ext;
                if (fill_q < KW'(2**DEPTH_LOG2)) begin
                    fill_d = fill_q + KW'(1);
                end
            end
            shifted    = sum_d >>> k_q;
            data_out_d = shifted[MSB:0];
`ifdef MOVING_AVERAGE_FILL_GATE_EN
            en_out_d   = (fill_d >= win);
`else
            en_out_d   = 1'b1;
`endif
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            k_q        <= KW'(DEFAULT_WIN_LOG2);
            fill_q     <= '0;
            wr_ptr_q   <= '0;
            sum_q      <= '0;
            data_out_q <= '0;
            en_out_q   <= 1'b0;
        end else begin
            k_q        <= k_d;
            fill_q     <= fill_d;
            wr_ptr_q   <= wr_ptr_d;
            sum_q      <= sum_d;
            data_out_q <= data_out_d;
            en_out_q   <= en_out_d;
        end
    end

    assign data_out    = data_out_q;
    assign data_en_out = en_out_q;
    assign full        = window_full;

    assign unused_bits = ^{shifted[SUMW-1:MSB+1], param_in[MSB:KW]};

endmodule

// File: tb/tb_moving_average.sv
// Directed scoreboard bench for moving_average (default parameters).
module tb_moving_average;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] data_in;
    logic        data_en;
    logic [31:0] param_in;
    logic        param_en;
    logic [31:0] data_out;
    logic        data_en_out;
    logic        full;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] d;
        logic        f;
    } exp_t;

    exp_t sb_q[$];

    always #5 clk = ~clk;

    moving_average #(
        .MSB              (31),
        .DEPTH_LOG2       (4),
        .DEFAULT_WIN_LOG2 (2)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .data_in     (data_in),
        .data_en     (data_en),
        .param_in    (param_in),
        .param_en    (param_en),
        .data_out    (data_out),
        .data_en_out (data_en_out),
        .full        (full)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Expected outputs are queued only where the DUT is meant to emit one.
    task automatic push_exp(input logic [31:0] d, input logic f);
        exp_t e;
        e.d = d;
        e.f = f;
`ifdef MOVING_AVERAGE_FILL_GATE_EN
        if (f) sb_q.push_back(e);
`else
        sb_q.push_back(e);
`endif
    endtask

    task automatic send(input logic [31:0] v, input logic [31:0] exp_d, input logic exp_f);
        @(negedge clk);
        data_in = v;
        data_en = 1'b1;
        push_exp(exp_d, exp_f);
        @(negedge clk);
        data_en = 1'b0;
    endtask

    task automatic load_param(input logic [31:0] v);
        @(negedge clk);
        param_in = v;
        param_en = 1'b1;
        @(negedge clk);
        param_en = 1'b0;
        chk("param_full_low", {31'b0, full}, 32'd0);
        chk("param_no_en_out", {31'b0, data_en_out}, 32'd0);
    endtask

    always @(negedge clk) begin
        if (data_en_out === 1'b1) begin
            checks++;
            assert (sb_q.size() != 0) else begin
                errors++;
                $error("FAIL unexpected_out observed=%h expected=none", data_out);
            end
            if (sb_q.size() != 0) begin
                exp_t e;
                e = sb_q.pop_front();
                chk("out_data", data_out, e.d);
                chk("out_full", {31'b0, full}, {31'b0, e.f});
            end
        end
    end

    initial begin
        longint s;
        rst      = 1'b1;
        data_in  = '0;
        data_en  = 1'b0;
        param_in = '0;
        param_en = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_data_out", data_out, 32'd0);
        chk("rst_en_out", {31'b0, data_en_out}, 32'd0);
        chk("rst_full", {31'b0, full}, 32'd0);
        rst = 1'b0;

        // Default k=2: zero-filled partial means, then steady window.
        send(32'd4,  32'd1,  1'b0);
        send(32'd8,  32'd3,  1'b0);
        send(32'd12, 32'd6,  1'b0);
        send(32'd16, 32'd10, 1'b1);
        send(32'd20, 32'd14, 1'b1);

        load_param(32'd0);
        send(32'hFFFF_FFFD, 32'hFFFF_FFFD, 1'b1);

        load_param(32'd1);
        send(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        send(32'd0,         32'hFFFF_FFFF, 1'b1);

        // Simultaneous strobes: parameter wins (9 clamps to 4), sample dropped.
        @(negedge clk);
        param_in = 32'd9;
        param_en = 1'b1;
        data_in  = 32'd123;
        data_en  = 1'b1;
        @(negedge clk);
        param_en = 1'b0;
        data_en  = 1'b0;
        chk("both_no_en_out", {31'b0, data_en_out}, 32'd0);
        chk("both_full_low", {31'b0, full}, 32'd0);

        for (int i = 1; i <= 16; i++) begin
            s = longint'(i) * 64'sh7FFF_FFFF;
            send(32'h7FFF_FFFF, 32'(s >>> 4), (i == 16));
        end
        repeat (3) @(negedge clk);
        chk("hold_data_out", data_out, 32'h7FFF_FFFF);
        chk("hold_en_out", {31'b0, data_en_out}, 32'd0);
        chk("hold_full", {31'b0, full}, 32'd1);

        // Reset right after an accepted sample must swallow its output.
        load_param(32'd0);
        @(negedge clk);
        data_in = 32'd5;
        data_en = 1'b1;
        @(posedge clk);
        #1;
        data_en = 1'b0;
        rst     = 1'b1;
        @(negedge clk);
        chk("midrst_en_out", {31'b0, data_en_out}, 32'd0);
        chk("midrst_full", {31'b0, full}, 32'd0);
        chk("midrst_data_out", data_out, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        send(32'd8, 32'd2, 1'b0);

        for (int i = 0; i < 20 && sb_q.size() != 0; i++) @(negedge clk);
        checks++;
        assert (sb_q.size() == 0) else begin
            errors++;
            $error("FAIL missing_outputs observed=%0d expected=0", sb_q.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
